// File: rtl/mfp_ahb_pkg.sv
// Shared definitions for the AHB-Lite RAM slave.
// Holds the HTRANS and HSIZE codes, the FSM state encoding, and small
// helpers that decode byte-lane enables and detect misaligned transfers.
package mfp_ahb_pkg;

   localparam logic [1:0] HTRANS_IDLE   = 2'b00;
   localparam logic [1:0] HTRANS_BUSY   = 2'b01;
   localparam logic [1:0] HTRANS_NONSEQ = 2'b10;
   localparam logic [1:0] HTRANS_SEQ    = 2'b11;

   localparam logic [2:0] HSIZE_BYTE = 3'd0;
   localparam logic [2:0] HSIZE_HALF = 3'd1;
   localparam logic [2:0] HSIZE_WORD = 3'd2;

   typedef enum logic [2:0] {
      StIdle  = 3'd0,
      StRwait = 3'd1,
      StWwait = 3'd2,
      StErr1  = 3'd3,
      StErr2  = 3'd4
   } ahb_state_e;

   // Little-endian lane enables for an aligned access.
   function automatic logic [3:0] lane_en(input logic [2:0] size, input logic [1:0] addr);
      logic [3:0] be;
      be = 4'b0000;
      case (size)
         HSIZE_BYTE: be = 4'b0001 << addr;
         HSIZE_HALF: be = addr[1] ? 4'b1100 : 4'b0011;
         HSIZE_WORD: be = 4'b1111;
         default:    be = 4'b0000;
      endcase
      return be;
   endfunction

   function automatic logic is_misaligned(input logic [2:0] size, input logic [1:0] addr);
      return ((size == HSIZE_HALF) && addr[0])
          || ((size == HSIZE_WORD) && (addr != 2'b00))
          || (size > HSIZE_WORD);
   endfunction

endpackage

// File: rtl/mfp_ram_be.sv
// Synchronous 4-lane byte-enable RAM, one write port and one read port.
// Ports:
//   clk            clock, rising edge
//   rst            synchronous clear of the read-data register only
//   we, be         write enable and per-lane byte enables
//   waddr, wdata   write word address and data
//   re, raddr      read enable and word address
//   rdata          registered read data, held until the next read
// A read hitting the word being written on the same edge returns the new
// bytes on the enabled lanes and the stored bytes elsewhere.
module mfp_ram_be #(
   parameter int unsigned WORD_AW = 12
) (
   input  logic               clk,
   input  logic               rst,
   input  logic               we,
   input  logic [3:0]         be,
   input  logic [WORD_AW-1:0] waddr,
   input  logic [31:0]        wdata,
   input  logic               re,
   input  logic [WORD_AW-1:0] raddr,
   output logic [31:0]        rdata
);

   localparam int unsigned Depth = 2 ** WORD_AW;

   logic [31:0] mem [Depth];
   logic [31:0] rd_merged;

   always_ff @(posedge clk) begin
      for (int i = 0; i < 4; i++) begin
         if (we && be[i]) begin
            mem[waddr][8*i +: 8] <= wdata[8*i +: 8];
         end
      end
   end

   always_comb begin
      rd_merged = mem[raddr];
      for (int i = 0; i < 4; i++) begin
         if (we && be[i] && (waddr == raddr)) begin
            rd_merged[8*i +: 8] = wdata[8*i +: 8];
         end
      end
   end

   always_ff @(posedge clk) begin
      if (rst) begin
         rdata <= '0;
      end else if (re) begin
         rdata <= rd_merged;
      end
   end

endmodule

// File: rtl/mfp_ahb_ram_wait.sv
// AHB-Lite RAM slave with configurable read/write wait states.
// Ports:
//   HCLK, HRESET        clock and synchronous active-high reset
//   HSEL, HADDR, HTRANS, HWRITE, HSIZE, HWDATA   AHB-Lite request
//   HBURST, HPROT, HMASTLOCK                     accepted and ignored
//   HRDATA, HREADY, HRESP                        AHB-Lite response
// Reads sample the RAM at the acceptance edge; writes commit on the edge
// that ends the final data-phase cycle. Misaligned transfers get the
// two-cycle ERROR response and touch neither RAM nor HRDATA.
module mfp_ahb_ram_wait
   import mfp_ahb_pkg::*;
#(
   parameter int unsigned ADDR_WIDTH = 14,
   parameter int unsigned READ_WAIT  = 1,
   parameter int unsigned WRITE_WAIT = 0
) (
   input  logic        HCLK,
   input  logic        HRESET,
   input  logic        HSEL,
   input  logic [31:0] HADDR,
   input  logic [1:0]  HTRANS,
   input  logic        HWRITE,
   input  logic [2:0]  HSIZE,
   input  logic [31:0] HWDATA,
   input  logic [2:0]  HBURST,
   input  logic [3:0]  HPROT,
   input  logic        HMASTLOCK,
   output logic [31:0] HRDATA,
   output logic        HREADY,
   output logic        HRESP
);

   localparam logic [3:0] RdWait = 4'(READ_WAIT);
   localparam logic [3:0] WrWait = 4'(WRITE_WAIT);

   ahb_state_e            state_q, state_d;
   logic [3:0]            cnt_q, cnt_d;
   logic [ADDR_WIDTH-1:0] haddr_q;
   logic                  hwrite_q;
   logic [2:0]            hsize_q;
   logic                  dphase_q, dphase_d;

   logic accept;
   logic misalign;
   logic ram_we;
   logic ram_re;

   logic unused_inputs;
   assign unused_inputs = ^{HBURST, HPROT, HMASTLOCK, HADDR[31:ADDR_WIDTH]};

   assign accept   = HREADY && HSEL && HTRANS[1];
   assign misalign = is_misaligned(HSIZE, HADDR[1:0]);

   // State register
   always_ff @(posedge HCLK) begin
      if (HRESET) begin
         state_q <= StIdle;
         cnt_q   <= '0;
      end else begin
         state_q <= state_d;
         cnt_q   <= cnt_d;
      end
   end

   // Next-state logic
   always_comb begin
      state_d = state_q;
      cnt_d   = cnt_q;
      unique case (state_q)
         StIdle, StErr2: begin
            state_d = StIdle;
            if (accept) begin
               if (misalign) begin
                  state_d = StErr1;
               end else if (HWRITE) begin
                  cnt_d   = WrWait;
                  state_d = (WrWait == 4'd0) ? StIdle : StWwait;
               end else begin
                  cnt_d   = RdWait;
                  state_d = (RdWait == 4'd0) ? StIdle : StRwait;
               end
            end
         end
         StRwait, StWwait: begin
            if (cnt_q <= 4'd1) begin
               cnt_d   = 4'd0;
               state_d = StIdle;
            end else begin
               cnt_d = cnt_q - 4'd1;
            end
         end
         StErr1: state_d = StErr2;
         default: state_d = StIdle;
      endcase
   end

   // Outputs
   always_comb begin
      HREADY = (state_q == StIdle) || (state_q == StErr2);
      HRESP  = (state_q == StErr1) || (state_q == StErr2);
   end

   // dphase_q marks an aligned transfer whose data phase is still open.
   always_comb begin
      dphase_d = dphase_q;
      if (accept) begin
         dphase_d = !misalign;
      end else if (HREADY) begin
         dphase_d = 1'b0;
      end
   end

   always_ff @(posedge HCLK) begin
      if (HRESET) begin
         haddr_q  <= '0;
         hwrite_q <= 1'b0;
         hsize_q  <= '0;
         dphase_q <= 1'b0;
      end else begin
         dphase_q <= dphase_d;
         if (accept) begin
            haddr_q  <= HADDR[ADDR_WIDTH-1:0];
            hwrite_q <= HWRITE;
            hsize_q  <= HSIZE;
         end
      end
   end

   // A write commits when its last data-phase cycle completes; a reset on
   // that edge discards it.
   assign ram_we = dphase_q && hwrite_q && HREADY && !HRESET;
   assign ram_re = accept && !HWRITE && !misalign && !HRESET;

   mfp_ram_be #(
      .WORD_AW(ADDR_WIDTH - 2)
   ) u_ram (
      .clk  (HCLK),
      .rst  (HRESET),
      .we   (ram_we),
      .be   (lane_en(hsize_q, haddr_q[1:0])),
      .waddr(haddr_q[ADDR_WIDTH-1:2]),
      .wdata(HWDATA),
      .re   (ram_re),
      .raddr(HADDR[ADDR_WIDTH-1:2]),
      .rdata(HRDATA)
   );

endmodule
